gmux_sel_seq: RTL and testbench



---
 rtl/gmux_seq_pkg.sv | 20 ++
 rtl/gmux_seq_cnt.sv | 37 +++
 rtl/gmux_sel_seq.sv | 152 +++++++++++++++
 tb/tb_gmux_sel_seq.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/gmux_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gmux_seq_pkg
// Description : Shared state encoding and defaults for the GMUX select
//               sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package gmux_seq_pkg;

  // Default width of the gate/settle down-counter
  localparam int CNT_W_DEF = 8;

  // Sequencer state encoding
  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_DRAIN  = 2'd1;
  localparam logic [1:0] c_SETTLE = 2'd2;
  localparam logic [1:0] c_DONE   = 2'd3;

endpackage : gmux_seq_pkg
`default_nettype wire

// File: rtl/gmux_seq_cnt.sv
`default_nettype none
// ============================================================================
// Module      : gmux_seq_cnt
// Description : Loadable down-counter with a zero flag. Holds at zero until
//               reloaded.
// Revision    : 1.0 - initial release
// ============================================================================
module gmux_seq_cnt
  import gmux_seq_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  // Load takes priority over decrement; never wraps below zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule : gmux_seq_cnt
`default_nettype wire

// File: rtl/gmux_sel_seq.sv
`default_nettype none
// ============================================================================
// Module      : gmux_sel_seq
// Description : Glitch-safe select sequencer for a global clock mux. Gates
//               the downstream enable, drains, flips the select, settles,
//               re-enables and acknowledges.
// Revision    : 1.0 - initial release
// ============================================================================
module gmux_sel_seq
  import gmux_seq_pkg::*;
#(
  parameter int   GATE_CYCLES   = 4,
  parameter int   SETTLE_CYCLES = 8,
  parameter int   CNT_W         = CNT_W_DEF,
  parameter logic SEL_RESET     = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic req,
  input  logic req_sel,
  input  logic err_clr,
  output logic sel,
  output logic clk_en,
  output logic busy,
  output logic ack,
  output logic err
);

  // Counter reload values: the counted state lasts (value + 1) cycles
  localparam logic [CNT_W-1:0] c_GATE_LD   = CNT_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);

  logic [1:0]       r_state;
  logic [1:0]       w_next;
  logic             r_tgt;
  logic             r_sel;
  logic             r_clk_en;
  logic             r_busy;
  logic             r_ack;
  logic             r_err;

  logic             w_zero;
  logic             w_load;
  logic [CNT_W-1:0] w_load_val;
  logic             w_dec;
  logic             w_tgt_ld;
  logic             w_sel_upd;
  logic             w_clk_en_d;
  logic             w_busy_d;
  logic             w_ack_d;
  logic             w_err_set;

  gmux_seq_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_dec      (w_dec),
    .o_zero     (w_zero)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state: a request matching the current select short-cuts to DONE
  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE: begin
        if (req) begin
          w_next = (req_sel == r_sel) ? c_DONE : c_DRAIN;
        end
      end
      c_DRAIN:  if (w_zero) w_next = c_SETTLE;
      c_SETTLE: if (w_zero) w_next = c_DONE;
      c_DONE:   w_next = c_IDLE;
      default:  w_next = c_IDLE;
    endcase
  end

  // Datapath controls and next values of the registered outputs
  always_comb begin
    w_load     = 1'b0;
    w_load_val = '0;
    w_dec      = 1'b0;
    w_tgt_ld   = 1'b0;
    w_sel_upd  = 1'b0;
    case (r_state)
      c_IDLE: begin
        if (req) begin
          w_tgt_ld = 1'b1;
          if (req_sel != r_sel) begin
            w_load     = 1'b1;
            w_load_val = c_GATE_LD;
          end
        end
      end
      c_DRAIN: begin
        if (w_zero) begin
          w_sel_upd  = 1'b1;
          w_load     = 1'b1;
          w_load_val = c_SETTLE_LD;
        end else begin
          w_dec = 1'b1;
        end
      end
      c_SETTLE: w_dec = !w_zero;
      default: ;
    endcase
    w_clk_en_d = !((w_next == c_DRAIN) || (w_next == c_SETTLE));
    w_busy_d   = (w_next != c_IDLE);
    w_ack_d    = (w_next == c_DONE);
    // A changed select while a sequence is in flight is a protocol error
    w_err_set  = r_busy && req && (req_sel != r_tgt);
  end

  // Output and target registers; select moves only on leaving DRAIN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tgt    <= SEL_RESET;
      r_sel    <= SEL_RESET;
      r_clk_en <= 1'b1;
      r_busy   <= 1'b0;
      r_ack    <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      if (w_tgt_ld)  r_tgt <= req_sel;
      if (w_sel_upd) r_sel <= r_tgt;
      r_clk_en <= w_clk_en_d;
      r_busy   <= w_busy_d;
      r_ack    <= w_ack_d;
      if (w_err_set)    r_err <= 1'b1;
      else if (err_clr) r_err <= 1'b0;
    end
  end

  assign sel    = r_sel;
  assign clk_en = r_clk_en;
  assign busy   = r_busy;
  assign ack    = r_ack;
  assign err    = r_err;

endmodule : gmux_sel_seq
`default_nettype wire

// File: tb/tb_gmux_sel_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_gmux_sel_seq
// Description : Self-checking bench for gmux_sel_seq. Two instances: default
//               timing, and 1/1-cycle boundary timing with SEL_RESET=1.
//               Expectations come from a per-request event timeline.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gmux_sel_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst     [2];
  logic req     [2];
  logic req_sel [2];
  logic err_clr [2];
  logic sel     [2];
  logic clk_en  [2];
  logic busy    [2];
  logic ack     [2];
  logic err     [2];

  int gc      [2];
  int sc      [2];
  bit sel_rst [2];
  bit exp_sel [2];
  bit exp_err [2];

  int n_tests = 0;
  int n_fail  = 0;

  gmux_sel_seq dut0 (
    .clk     (clk),
    .reset   (rst[0]),
    .req     (req[0]),
    .req_sel (req_sel[0]),
    .err_clr (err_clr[0]),
    .sel     (sel[0]),
    .clk_en  (clk_en[0]),
    .busy    (busy[0]),
    .ack     (ack[0]),
    .err     (err[0])
  );

  gmux_sel_seq #(
    .GATE_CYCLES   (1),
    .SETTLE_CYCLES (1),
    .CNT_W         (4),
    .SEL_RESET     (1'b1)
  ) dut1 (
    .clk     (clk),
    .reset   (rst[1]),
    .req     (req[1]),
    .req_sel (req_sel[1]),
    .err_clr (err_clr[1]),
    .sel     (sel[1]),
    .clk_en  (clk_en[1]),
    .busy    (busy[1]),
    .ack     (ack[1]),
    .err     (err[1])
  );

  task automatic chk(input string tag, input logic obs, input logic exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp_v);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input int d, input string tag, input bit e_busy,
                            input bit e_ack, input bit e_en, input bit e_sel,
                            input bit e_err);
    chk($sformatf("d%0d_%s_busy", d, tag), busy[d], e_busy);
    chk($sformatf("d%0d_%s_ack", d, tag), ack[d], e_ack);
    chk($sformatf("d%0d_%s_clk_en", d, tag), clk_en[d], e_en);
    chk($sformatf("d%0d_%s_sel", d, tag), sel[d], e_sel);
    chk($sformatf("d%0d_%s_err", d, tag), err[d], e_err);
  endtask

  // Sticky error: set while a sequence is in flight and the request disagrees
  // with the accepted target; set beats clear.
  task automatic model_err(input int d, input bit in_flight, input bit tgt);
    if (in_flight && req[d] && (req_sel[d] != tgt)) exp_err[d] = 1'b1;
    else if (err_clr[d]) exp_err[d] = 1'b0;
  endtask

  // mode: 0 = err_clr low, 1 = random err_clr, 2 = err_clr high
  task automatic idle(input int d, input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      err_clr[d] = (mode == 2) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      model_err(d, 1'b0, 1'b0);
      tick();
      check_outs(d, "idle", 1'b0, 1'b0, 1'b1, exp_sel[d], exp_err[d]);
    end
    err_clr[d] = 1'b0;
  endtask

  // One request accepted at cycle 0. Expected outputs per cycle k follow
  // from the timeline: enable low on 1..G+S, select flips at 1+G, ack at
  // 1+G+S (or 1 when the select already matches). Optional events: drop req
  // at drop_at, flip req_sel at flip_at, reset at rst_at.
  task automatic run_req(input int d, input bit rsel, input int drop_at,
                         input int flip_at, input int rst_at, input bit rnd_clr);
    bit old_sel;
    bit sw;
    bit in_flight;
    int ack_c;
    int sel_c;
    old_sel = exp_sel[d];
    sw      = (rsel != old_sel);
    ack_c   = sw ? (1 + gc[d] + sc[d]) : 1;
    sel_c   = 1 + gc[d];
    req[d]     = 1'b1;
    req_sel[d] = rsel;
    for (int k = 1; k <= ack_c + 1; k++) begin
      in_flight  = (k - 1 >= 1) && (k - 1 <= ack_c);
      err_clr[d] = rnd_clr ? 1'($urandom_range(0, 1)) : 1'b0;
      model_err(d, in_flight, rsel);
      tick();
      if (k <= ack_c) begin
        check_outs(d, $sformatf("c%0d", k), 1'b1, (k == ack_c),
                   (!sw || (k == ack_c)),
                   (sw && (k >= sel_c)) ? rsel : old_sel, exp_err[d]);
      end else begin
        check_outs(d, "post", 1'b0, 1'b0, 1'b1, rsel, exp_err[d]);
      end
      if (k == rst_at) begin
        #2 rst[d] = 1'b1;
        #1;
        exp_sel[d] = sel_rst[d];
        exp_err[d] = 1'b0;
        check_outs(d, "async_rst", 1'b0, 1'b0, 1'b1, sel_rst[d], 1'b0);
        req[d]     = 1'b0;
        err_clr[d] = 1'b0;
        tick();
        rst[d] = 1'b0;
        return;
      end
      if ((k == ack_c) || (k == drop_at)) req[d] = 1'b0;
      if (k == flip_at) req_sel[d] = !rsel;
    end
    exp_sel[d] = rsel;
    err_clr[d] = 1'b0;
  endtask

  initial begin
    gc      = '{4, 1};
    sc      = '{8, 1};
    sel_rst = '{1'b0, 1'b1};
    exp_sel = '{1'b0, 1'b1};
    exp_err = '{1'b0, 1'b0};
    for (int d = 0; d < 2; d++) begin
      rst[d]     = 1'b1;
      req[d]     = 1'b0;
      req_sel[d] = 1'b0;
      err_clr[d] = 1'b0;
    end
    repeat (3) tick();
    for (int d = 0; d < 2; d++) check_outs(d, "reset", 1'b0, 1'b0, 1'b1, sel_rst[d], 1'b0);
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    for (int d = 0; d < 2; d++) idle(d, 2, 0);

    // Basic switch 0 -> 1 with defaults
    run_req(0, 1'b1, 0, -1, -1, 1'b0);
    idle(0, 2, 0);
    // No-op request
    run_req(0, 1'b1, 0, -1, -1, 1'b0);
    idle(0, 1, 0);
    // Request dropped mid-sequence
    run_req(0, 1'b0, 3, -1, -1, 1'b0);
    idle(0, 1, 0);
    // Protocol error, then clear at cycle 20
    run_req(0, 1'b1, 0, 6, -1, 1'b0);
    idle(0, 6, 0);
    idle(0, 1, 2);
    idle(0, 2, 0);
    // Reset during SETTLE, then a fresh request
    run_req(0, !exp_sel[0], 0, -1, 7, 1'b0);
    idle(0, 2, 0);
    run_req(0, !exp_sel[0], 0, -1, -1, 1'b0);
    idle(0, 1, 0);

    // Boundary timing, back-to-back alternating requests
    for (int i = 0; i < 6; i++) run_req(1, !exp_sel[1], 0, -1, -1, 1'b0);
    idle(1, 2, 0);

    // Randomized traffic on both instances
    for (int i = 0; i < 40; i++) begin
      int  d;
      bit  rsel;
      int  drop_at;
      int  flip_at;
      d       = $urandom_range(0, 1);
      rsel    = 1'($urandom_range(0, 1));
      drop_at = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 14) : 0;
      flip_at = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 14) : -1;
      run_req(d, rsel, drop_at, flip_at, -1, 1'($urandom_range(0, 1)));
      idle(d, $urandom_range(0, 3), 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_gmux_sel_seq
`default_nettype wire
